// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one single-port synchronous RAM between an instruction-fetch port
//   (read only) and an execute-stage port (load/store). Execute requests win
//   arbitration. A write holds the RAM for a write cycle plus a turnaround
//   cycle. Reads are pipelined one per cycle, with a two-stage owner tag
//   that routes the read-valid pulse to the requester that issued the read.
//   A branch flush drops fetch reads that are still in flight.
//
//   Optional build macro RAM_ARB_FAIRNESS_EN adds an anti-starvation counter.
//   Once STARVE_LIMIT execute grants have been issued while fetch was
//   waiting, the next arbitration cycle serves fetch. With the macro
//   undefined, execute always has priority and the counter does not exist.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   if_req, if_addr            fetch read request (held until if_gnt)
//   ex_req, ex_we, ex_addr,    execute load/store request (held until ex_gnt)
//   ex_wdata
//   flush                      branch flush, kills in-flight fetch reads
//   if_gnt, ex_gnt             combinational grant pulses
//   if_stall, ex_stall         req && !gnt
//   if_rvalid, ex_rvalid       read data valid, routed to the owner of the read
//   rdata                      shared read data (ram_dout)
//   ram_addr, ram_din, ram_wea registered RAM controls
//   ram_dout                   RAM read data, one cycle after ram_addr
//
// State table
//   ARB     | arbitrate; issue at most one grant
//   WR      | write in progress, ram_wea high
//   WR_TURN | write turnaround, no grants

module ram_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              ex_req,
  input  logic              ex_we,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              flush,
  output logic              if_gnt,
  output logic              ex_gnt,
  output logic              if_rvalid,
  output logic              ex_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              if_stall,
  output logic              ex_stall,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_wea,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {
    ARB     = 2'd0,
    WR      = 2'd1,
    WR_TURN = 2'd2
  } state_t;

  state_t state;

  // Read pipeline tags: stage 1 = address on the RAM, stage 2 = data out.
  logic rd1_v, rd1_ex;
  logic rd2_v, rd2_ex;

  logic arb_ok;
  logic fair_force;

  if (STARVE_LIMIT < 1) begin : g_limit_chk
    $error("STARVE_LIMIT must be at least 1");
  end

`ifdef RAM_ARB_FAIRNESS_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 2);

  logic [CNT_W-1:0] starve_cnt;

  // A flush blocks the fetch grant, so forcing fetch in that cycle would
  // waste the slot; execute keeps it instead.
  assign fair_force = (starve_cnt >= CNT_W'(STARVE_LIMIT)) && if_req && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (if_gnt || !if_req) begin
      starve_cnt <= '0;
    end else if (ex_gnt && (starve_cnt < CNT_W'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign fair_force = 1'b0;
`endif

  always_comb begin
    arb_ok = rst_n && (state == ARB);
    ex_gnt = arb_ok && ex_req && !fair_force;
    if_gnt = arb_ok && if_req && !flush && !ex_gnt;
  end

  assign if_stall  = if_req && !if_gnt;
  assign ex_stall  = ex_req && !ex_gnt;

  // Gated by rst_n so that a read in flight when reset arrives never reports.
  assign if_rvalid = rst_n && rd2_v && !rd2_ex;
  assign ex_rvalid = rst_n && rd2_v && rd2_ex;
  assign rdata     = ram_dout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ARB;
      rd1_v    <= 1'b0;
      rd1_ex   <= 1'b0;
      rd2_v    <= 1'b0;
      rd2_ex   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      ram_wea  <= 1'b0;
    end else begin
      ram_wea <= 1'b0;
      if (ex_gnt) begin
        ram_addr <= ex_addr;
        ram_wea  <= ex_we;
        if (ex_we) begin
          ram_din <= ex_wdata;
        end
      end else if (if_gnt) begin
        ram_addr <= if_addr;
      end

      case (state)
        ARB:     if (ex_gnt && ex_we) state <= WR;
        WR:      state <= WR_TURN;
        WR_TURN: state <= ARB;
        default: state <= ARB;
      endcase

      rd1_v  <= (ex_gnt && !ex_we) || if_gnt;
      rd1_ex <= ex_gnt;
      // A fetch read at stage 1 during a flush is dropped before it reports.
      rd2_v  <= rd1_v && !(flush && !rd1_ex);
      rd2_ex <= rd1_ex;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter: directed scenarios followed by random
// traffic. A reference model predicts grants, RAM controls and read data;
// expected reads go to per-port queues that a negedge monitor checks.

module tb_ram_port_arbiter;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        ex_req;
  logic        ex_we;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic        flush;
  logic        if_gnt, ex_gnt, if_rvalid, ex_rvalid, if_stall, ex_stall;
  logic [31:0] rdata;
  logic [31:0] ram_addr;
  logic [31:0] ram_din;
  logic        ram_wea;
  logic [31:0] ram_dout;

  ram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr),
    .ex_req(ex_req), .ex_we(ex_we), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .flush(flush),
    .if_gnt(if_gnt), .ex_gnt(ex_gnt),
    .if_rvalid(if_rvalid), .ex_rvalid(ex_rvalid),
    .rdata(rdata),
    .if_stall(if_stall), .ex_stall(ex_stall),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_wea(ram_wea),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // Environment RAM, restored to its initial image while reset is low.
  logic [31:0] ram [256];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
      ram_dout <= '0;
    end else begin
      if (ram_wea) ram[ram_addr[7:0]] <= ram_din;
      ram_dout <= ram[ram_addr[7:0]];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state
  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t        if_q[$];
  exp_t        ex_q[$];
  logic [31:0] shadow [256];
  int          cyc     = 0;
  bit          started = 1'b0;
  int          busy    = 0;
  int          starve  = 0;
  logic [31:0] exp_addr, exp_din;
  logic        exp_wea;
  logic        m_ig, m_eg;

  // Stimulus for the next cycle
  logic        d_rst_n, d_if_req, d_ex_req, d_ex_we, d_flush;
  logic [31:0] d_if_addr, d_ex_addr, d_ex_wdata;

  task automatic cycle();
    logic ig, eg, fair;
    @(posedge clk);
    cyc++;
    #1;
    if (started) begin
      chk("ram_addr", ram_addr, exp_addr);
      chk("ram_wea",  ram_wea,  exp_wea);
      chk("ram_din",  ram_din,  exp_din);
    end
    rst_n    = d_rst_n;
    if_req   = d_if_req;
    if_addr  = d_if_addr;
    ex_req   = d_ex_req;
    ex_we    = d_ex_we;
    ex_addr  = d_ex_addr;
    ex_wdata = d_ex_wdata;
    flush    = d_flush;
    #1;
    ig = 1'b0;
    eg = 1'b0;
    fair = 1'b0;
    if (d_rst_n && busy == 0) begin
`ifdef RAM_ARB_FAIRNESS_EN
      fair = (starve >= STARVE_LIMIT) && d_if_req && !d_flush;
`endif
      eg = d_ex_req && !fair;
      ig = d_if_req && !d_flush && !eg;
    end
    chk("if_gnt",   if_gnt,   ig);
    chk("ex_gnt",   ex_gnt,   eg);
    chk("if_stall", if_stall, d_if_req && !ig);
    chk("ex_stall", ex_stall, d_ex_req && !eg);
    m_ig = ig;
    m_eg = eg;
    if (!d_rst_n) begin
      busy   = 0;
      starve = 0;
      if_q.delete();
      ex_q.delete();
      exp_addr = '0;
      exp_din  = '0;
      exp_wea  = 1'b0;
      for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
      started = 1'b1;
    end else begin
      if (d_flush) begin
        while (if_q.size() > 0 && if_q[$].due > cyc) void'(if_q.pop_back());
      end
      if (busy > 0) busy--;
      exp_wea = 1'b0;
      if (eg) begin
        exp_addr = d_ex_addr;
        if (d_ex_we) begin
          exp_wea = 1'b1;
          exp_din = d_ex_wdata;
          shadow[d_ex_addr[7:0]] = d_ex_wdata;
          busy = 2;
        end else begin
          ex_q.push_back('{cyc + 2, shadow[d_ex_addr[7:0]]});
        end
      end else if (ig) begin
        exp_addr = d_if_addr;
        if_q.push_back('{cyc + 2, shadow[d_if_addr[7:0]]});
      end
      if (ig || !d_if_req) starve = 0;
      else if (eg && starve < STARVE_LIMIT) starve++;
    end
  endtask

  // Monitor: compare read-valid pulses and data against the queues.
  always @(negedge clk) begin
    logic exp_v;
    if (started) begin
      exp_v = (if_q.size() > 0) && (if_q[0].due == cyc);
      chk("if_rvalid", if_rvalid, exp_v);
      if (exp_v) begin
        if (if_rvalid) chk("if_rdata", rdata, if_q[0].data);
        void'(if_q.pop_front());
      end
      exp_v = (ex_q.size() > 0) && (ex_q[0].due == cyc);
      chk("ex_rvalid", ex_rvalid, exp_v);
      if (exp_v) begin
        if (ex_rvalid) chk("ex_rdata", rdata, ex_q[0].data);
        void'(ex_q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    d_if_req = 1'b0;
    d_ex_req = 1'b0;
    d_flush  = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int first;
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; ex_req = 1'b0; ex_we = 1'b0;
    ex_addr = '0; ex_wdata = '0; flush = 1'b0;
    d_rst_n = 1'b0; d_if_req = 1'b0; d_if_addr = '0; d_ex_req = 1'b0;
    d_ex_we = 1'b0; d_ex_addr = '0; d_ex_wdata = '0; d_flush = 1'b0;

    cycle();
    cycle();
    d_rst_n = 1'b1;
    cycle();
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wea",  ram_wea,  0);
    chk("rst_ram_din",  ram_din,  0);
    chk("rst_rvalid",   {if_rvalid, ex_rvalid}, 0);

    // Lone fetch
    d_if_req = 1'b1; d_if_addr = 32'h10;
    cycle();
    chk("d028_if_gnt", if_gnt, 1);
    d_if_req = 1'b0;
    cycle();
    chk("d028_ram_addr", ram_addr, 32'h10);
    cycle();
    chk("d028_if_rvalid", if_rvalid, 1);
    chk("d028_rdata", rdata, init_val(32'h10));
    idle(2);

    // Write beats a simultaneous fetch
    d_if_req = 1'b1; d_if_addr = 32'h30;
    d_ex_req = 1'b1; d_ex_we = 1'b1; d_ex_addr = 32'h20; d_ex_wdata = 32'hDEADBEEF;
    cycle();
    chk("d029_ex_gnt", ex_gnt, 1);
    chk("d029_if_stall", if_stall, 1);
    d_ex_req = 1'b0;
    cycle();
    chk("d029_wea_on", ram_wea, 1);
    chk("d029_ram_din", ram_din, 32'hDEADBEEF);
    chk("d029_if_gnt_wr", if_gnt, 0);
    cycle();
    chk("d029_wea_off", ram_wea, 0);
    chk("d029_if_gnt_turn", if_gnt, 0);
    cycle();
    chk("d029_if_gnt", if_gnt, 1);
    d_if_req = 1'b0;
    d_ex_req = 1'b1; d_ex_we = 1'b0; d_ex_addr = 32'h20;
    cycle();
    chk("d029_rd_gnt", ex_gnt, 1);
    d_ex_req = 1'b0;
    cycle();
    cycle();
    chk("d029_ex_rvalid", ex_rvalid, 1);
    chk("d029_readback", rdata, 32'hDEADBEEF);
    idle(2);

    // Flush kills the in-flight fetch but not the load behind it
    d_if_req = 1'b1; d_if_addr = 32'h40;
    cycle();
    chk("d030_if_gnt", if_gnt, 1);
    d_if_req = 1'b0;
    d_flush = 1'b1; d_ex_req = 1'b1; d_ex_we = 1'b0; d_ex_addr = 32'h50;
    cycle();
    chk("d030_ex_gnt", ex_gnt, 1);
    d_flush = 1'b0; d_ex_req = 1'b0;
    cycle();
    chk("d030_if_killed", if_rvalid, 0);
    cycle();
    chk("d030_ex_rvalid", ex_rvalid, 1);
    chk("d030_rdata", rdata, init_val(32'h50));
    idle(2);

    // Starvation: loads held back to back with a fetch waiting
    first = 0;
    d_ex_req = 1'b1; d_ex_we = 1'b0; d_ex_addr = 32'h60;
    d_if_req = 1'b1; d_if_addr = 32'h70;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (if_gnt === 1'b1 && first == 0) first = i + 1;
      if (m_ig) d_if_req = 1'b0;
    end
`ifdef RAM_ARB_FAIRNESS_EN
    chk("d031_first_if_gnt", first, STARVE_LIMIT + 1);
`else
    chk("d031_first_if_gnt", first, 0);
`endif
    d_ex_req = 1'b0;
    if (d_if_req) begin
      cycle();
      chk("d031_if_gnt_after", if_gnt, 1);
      d_if_req = 1'b0;
    end
    idle(3);

    // Reset in the middle of a write
    d_ex_req = 1'b1; d_ex_we = 1'b1; d_ex_addr = 32'h80; d_ex_wdata = 32'h12345678;
    cycle();
    chk("d032_ex_gnt", ex_gnt, 1);
    d_ex_req = 1'b0;
    d_rst_n = 1'b0; d_if_req = 1'b1; d_if_addr = 32'h90;
    cycle();
    chk("d032_wea_in_wr", ram_wea, 1);
    chk("d032_gnt_in_rst", {if_gnt, ex_gnt}, 0);
    d_rst_n = 1'b1;
    cycle();
    chk("d032_wea_cleared", ram_wea, 0);
    chk("d032_addr_cleared", ram_addr, 0);
    chk("d032_if_gnt_arb", if_gnt, 1);
    d_if_req = 1'b0;
    idle(3);

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      if (!d_if_req && $urandom_range(0, 2) == 0) begin
        d_if_req  = 1'b1;
        d_if_addr = 32'($urandom_range(0, 31));
      end
      if (!d_ex_req && $urandom_range(0, 2) == 0) begin
        d_ex_req   = 1'b1;
        d_ex_we    = 1'($urandom_range(0, 1));
        d_ex_addr  = 32'($urandom_range(0, 31));
        d_ex_wdata = $urandom();
      end
      d_flush = ($urandom_range(0, 9) == 0);
      d_rst_n = ($urandom_range(0, 199) != 0);
      cycle();
      if (m_ig) d_if_req = 1'b0;
      if (m_eg) d_ex_req = 1'b0;
    end
    d_rst_n = 1'b1;
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, RAM address width.
REQ-002 Parameter DATA_W, default 32, RAM data width.
REQ-003 Parameter STARVE_LIMIT, default 4, max consecutive EX grants while IF waits (fairness build only).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset; one clock, reset is synchronous and active-low.
REQ-006 if_req, if_addr  input  1, ADDR_W  fetch read request and address, held stable until if_gnt.
REQ-007 ex_req, ex_we, ex_addr, ex_wdata  input  1, 1, ADDR_W, DATA_W  execute-stage load/store request, held stable until ex_gnt.
REQ-008 flush  input  1  branch flush from hazard detector.
REQ-009 if_gnt, ex_gnt  output  1 each  combinational one-cycle grant pulses.
REQ-010 if_rvalid, ex_rvalid  output  1 each  one-cycle read-data-valid pulses.
REQ-011 rdata  output  DATA_W  equals ram_dout, shared by both requesters.
REQ-012 if_stall, ex_stall  output  1 each  req AND NOT gnt, combinational.
REQ-013 ram_addr, ram_din, ram_wea  output  ADDR_W, DATA_W, 1  registered single-port RAM controls.
REQ-014 ram_dout  input  DATA_W  RAM read data, valid one cycle after ram_addr.

Function
REQ-015 FSM states: ARB, WR, WR_TURN; arbitration (grant issue) occurs only in ARB.
REQ-016 ARB priority: ex_req over if_req; at most one grant per cycle.
REQ-017 Grant in cycle T: ram_addr (and ram_din, ram_wea for writes) registered at T+1.
REQ-018 Read granted at T: matching rvalid asserted at T+2 for exactly one cycle; reads pipeline back-to-back, one per cycle.
REQ-019 Write granted at T: ram_wea=1 at T+1 (state WR), ram_wea=0 at T+2 (state WR_TURN, no grants), ARB again at T+3.
REQ-020 Read-owner tag shifts alongside each read (2-stage); rvalid routed to owner only.
REQ-021 flush at cycle F: suppresses if_rvalid for every fetch granted before F still in flight; ex reads and writes unaffected; if_gnt is forced 0 in cycle F.
REQ-022 No requests in ARB: ram_wea=0, ram_addr holds last value, no rvalid generated.
REQ-023 ex_req with ex_we=1 and if_req simultaneous: write granted, fetch stalled through WR and WR_TURN.

Reset
REQ-024 rst_n=0 at an edge: state ARB, read tags cleared, ram_addr=0, ram_din=0, ram_wea=0, rvalid outputs 0, fairness counter 0.
REQ-025 Grants forced 0 while rst_n=0; reset mid-write deasserts ram_wea at that edge; in-flight reads produce no rvalid.

Configuration
REQ-026 Macro RAM_ARB_FAIRNESS_EN defined: counter increments on each ex_gnt issued while if_req=1, clears on if_gnt or if_req=0; at STARVE_LIMIT, the next ARB cycle with if_req=1 grants IF regardless of ex_req.
REQ-027 Macro undefined: strict EX priority, counter not instantiated, STARVE_LIMIT ignored.

Verification
REQ-028 if_req=1, if_addr=0x10 alone -> if_gnt at T, ram_addr=0x10 at T+1, if_rvalid at T+2, rdata=RAM[0x10].
REQ-029 ex_req=1, ex_we=1, addr=0x20, wdata=0xDEADBEEF with if_req=1 -> ex_gnt at T, wea=1 at T+1, if_gnt at T+3; later read of 0x20 returns 0xDEADBEEF.
REQ-030 Fetch granted at T, flush at T+1 -> no if_rvalid at T+2; ex read granted at T+1 still gets ex_rvalid at T+3.
REQ-031 Fairness build, ex_req reads held 10 cycles, if_req held -> if_gnt on 5th arbitration cycle (after 4 ex_gnt); undefined build -> no if_gnt until ex_req drops.
REQ-032 rst_n=0 during WR -> ram_wea=0 next edge, all grants/rvalids 0, state ARB after rst_n=1.
